// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains burst_len words from the async FIFO read port
// into a 2-deep skid buffer and streams them out on m_valid/m_ready.
//
// Ports:
//   rd_clk, rstn         read-domain clock, async active-low reset
//   start, burst_len     burst request (IDLE only), word count
//   abort                stop issuing reads (RUN only)
//   busy, done           state != IDLE, 1-cycle end-of-burst pulse
//   words_out            output handshakes this burst
//   err_underflow        sticky FIFO underflow flag
//   rd_en, rd_data       FIFO read port (data 1 cycle after rd_en)
//   empty, underflow     FIFO status
//   m_valid, m_ready     output stream handshake
//   m_data               output word (buffer head)
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  rd_clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_out,
  output logic                  err_underflow,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  empty,
  input  logic                  underflow,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  words_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  hd;
  logic                  tl;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  err_q;

  logic                  pop;
  logic                  push;
  logic                  accept;
  logic [2:0]            need;

  assign pop    = m_valid & m_ready;
  assign push   = inflight;
  assign accept = start & (state == S_IDLE);

  // Entries that will be held next cycle if a new read is not issued;
  // a read is only issued if its word is guaranteed a free slot.
  assign need = {1'b0, occ}
              - {2'b00, pop}
              + {2'b00, inflight};

  assign rd_en = (state == S_RUN)
               & ~abort
               & ~empty
               & (issued < len_q)
               & (need < 3'd2);

  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign words_out     = words_q;
  assign err_underflow = err_q;
  assign m_valid       = (occ != 2'd0);
  assign m_data        = buf_q[hd];

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (burst_len != '0) state_n = S_RUN;
          else                 state_n = S_DONE;
        end
      end
      S_RUN: begin
        if ((issued == len_q) || abort)
          state_n = S_FLUSH;
      end
      S_FLUSH: begin
        if ((occ == 2'd0) && !inflight)
          state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      len_q   <= '0;
      issued  <= '0;
      words_q <= '0;
    end else if (accept) begin
      len_q   <= burst_len;
      issued  <= '0;
      words_q <= '0;
    end else begin
      if (rd_en) issued  <= issued + 1'b1;
      if (pop)   words_q <= words_q + 1'b1;
    end
  end

  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      inflight <= 1'b0;
      hd       <= 1'b0;
      tl       <= 1'b0;
      occ      <= 2'd0;
      for (int i = 0; i < 2; i++)
        buf_q[i] <= '0;
    end else begin
      inflight <= rd_en;
      if (push) begin
        buf_q[tl] <= rd_data;
        tl        <= ~tl;
      end
      if (pop) hd <= ~hd;
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn)          err_q <= 1'b0;
    else if (underflow) err_q <= 1'b1;
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: scenario tasks against a queue-based FIFO model
// and an in-order expected-word list for fifo_burst_reader.
module tb_fifo_burst_reader;

  logic       rd_clk;
  logic       rstn;
  logic       start;
  logic [7:0] burst_len;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] words_out;
  logic       err_underflow;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       underflow;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;

  int chk_cnt;
  int pass_cnt;

  logic [7:0] fifo_q [$];
  logic [7:0] wr_hist [$];

  int r_nrd, r_npop, r_viol;
  int r_rd_first, r_rd_last;
  int r_pop_first, r_pop_last;
  int r_done_c, r_words;
  bit r_done;
  int s_nrd;
  logic s_rd_en, s_busy, s_valid;
  logic [7:0] s_data;

  fifo_burst_reader #(
    .DATA_WIDTH(8),
    .LEN_WIDTH(8)
  ) dut (
    .rd_clk(rd_clk),
    .rstn(rstn),
    .start(start),
    .burst_len(burst_len),
    .abort(abort),
    .busy(busy),
    .done(done),
    .words_out(words_out),
    .err_underflow(err_underflow),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .underflow(underflow),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data)
  );

  initial begin
    rd_clk = 0;
    forever #5 rd_clk = ~rd_clk;
  end

  // FIFO read side: data appears one cycle after rd_en.
  always @(posedge rd_clk) begin
    if (rd_en && fifo_q.size() != 0)
      rd_data <= fifo_q.pop_front();
    empty <= (fifo_q.size() == 0);
  end

  task automatic fifo_put(input int n);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom);
      fifo_q.push_back(w);
      wr_hist.push_back(w);
    end
    if (n > 0) empty = 1'b0;
  endtask

  task automatic fifo_clear();
    fifo_q.delete();
    wr_hist.delete();
    empty = 1'b1;
  endtask

  task automatic run_burst(
    input int len, input int prefill,
    input int late_n, input int late_c,
    input int rdy_pct, input int hold_c,
    input int abort_n, input int snap_c,
    input int restart_c, input string nm
  );
    bit ab_pend;
    logic [7:0] exp_d;
    fifo_clear();
    fifo_put(prefill);
    r_nrd = 0; r_npop = 0; r_viol = 0;
    r_rd_first = -1; r_rd_last = -1;
    r_pop_first = -1; r_pop_last = -1;
    r_done = 0; r_done_c = -1; r_words = -1;
    s_nrd = -1;
    ab_pend = 0;
    @(negedge rd_clk);
    start = 1; burst_len = 8'(len);
    m_ready = 0; abort = 0;
    @(negedge rd_clk);
    start = 0;
    for (int c = 0; c < 400 && !r_done; c++) begin
      if (c > 0) @(negedge rd_clk);
      if (c == late_c) fifo_put(late_n);
      if (c == restart_c) begin
        start = 1; burst_len = 8'd7;
      end else start = 0;
      m_ready = (c >= hold_c)
        && ($urandom_range(99) < rdy_pct);
      abort = ab_pend;
      ab_pend = 0;
      #1;
      if (c == snap_c) begin
        s_nrd = r_nrd; s_rd_en = rd_en;
        s_busy = busy; s_valid = m_valid;
        s_data = m_data;
      end
      if (rd_en) begin
        if (empty) r_viol++;
        r_nrd++;
        if (r_rd_first < 0) r_rd_first = c;
        r_rd_last = c;
        if (abort_n > 0 && r_nrd == abort_n)
          ab_pend = 1;
      end
      if (m_valid && m_ready) begin
        exp_d = (r_npop < wr_hist.size())
          ? wr_hist[r_npop] : 8'hxx;
        chk_cnt++;
        if (m_data !== exp_d)
          $display("FAIL %s data[%0d]: got %h want %h",
            nm, r_npop, m_data, exp_d);
        else pass_cnt++;
        r_npop++;
        if (r_pop_first < 0) r_pop_first = c;
        r_pop_last = c;
      end
      if (r_nrd - r_npop > 2) r_viol++;
      if (done) begin
        r_done = 1; r_done_c = c;
        r_words = int'(words_out);
      end
    end
    start = 0; m_ready = 0; abort = 0;
    chk_cnt++;
    if (!r_done)
      $display("FAIL %s timeout: done got 0 want 1", nm);
    else pass_cnt++;
    chk_cnt++;
    if (r_viol != 0)
      $display("FAIL %s protocol: got %0d viol want 0",
        nm, r_viol);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    chk_cnt++;
    if ({busy, done, words_out, err_underflow,
         rd_en, m_valid, m_data} !== 21'd0)
      $display("FAIL reset_outs: got %b want 0",
        {busy, done, words_out, err_underflow,
         rd_en, m_valid, m_data});
    else pass_cnt++;
    @(negedge rd_clk);
    rstn = 1;
  endtask

  task automatic test_stream();
    run_burst(4, 4, 0, -1, 100, 0, 0, -1, -1, "stream");
    chk_cnt++;
    if (r_rd_first != 0 || r_rd_last != 3 || r_nrd != 4)
      $display("FAIL stream rd_en: got %0d..%0d n%0d want 0..3 n4",
        r_rd_first, r_rd_last, r_nrd);
    else pass_cnt++;
    chk_cnt++;
    if (r_pop_first != 2 || r_pop_last != 5)
      $display("FAIL stream pops: got %0d..%0d want 2..5",
        r_pop_first, r_pop_last);
    else pass_cnt++;
    chk_cnt++;
    if (r_done_c != r_pop_last + 2)
      $display("FAIL stream done_lat: got %0d want %0d",
        r_done_c, r_pop_last + 2);
    else pass_cnt++;
    chk_cnt++;
    if (r_words != 4)
      $display("FAIL stream words: got %0d want 4", r_words);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    run_burst(3, 3, 0, -1, 100, 10, 0, 9, -1, "bp");
    chk_cnt++;
    if (s_nrd != 2 || s_rd_en !== 1'b0)
      $display("FAIL bp stall: got n%0d rd_en %b want n2 0",
        s_nrd, s_rd_en);
    else pass_cnt++;
    chk_cnt++;
    if (s_valid !== 1'b1 || s_data !== wr_hist[0])
      $display("FAIL bp head: got %b/%h want 1/%h",
        s_valid, s_data, wr_hist[0]);
    else pass_cnt++;
    chk_cnt++;
    if (r_nrd != 3 || r_npop != 3 || r_words != 3)
      $display("FAIL bp count: got %0d/%0d/%0d want 3/3/3",
        r_nrd, r_npop, r_words);
    else pass_cnt++;
  endtask

  task automatic test_empty_stall();
    run_burst(5, 2, 3, 10, 100, 0, 0, 9, -1, "empty");
    chk_cnt++;
    if (s_nrd != 2 || s_rd_en !== 1'b0 || s_busy !== 1'b1)
      $display("FAIL empty stall: got n%0d rd%b busy%b want n2 0 1",
        s_nrd, s_rd_en, s_busy);
    else pass_cnt++;
    chk_cnt++;
    if (r_npop != 5 || r_words != 5)
      $display("FAIL empty count: got %0d/%0d want 5/5",
        r_npop, r_words);
    else pass_cnt++;
    chk_cnt++;
    if (r_done_c != r_pop_last + 2)
      $display("FAIL empty done_lat: got %0d want %0d",
        r_done_c, r_pop_last + 2);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    run_burst(8, 8, 0, -1, 100, 0, 2, -1, -1, "abort");
    chk_cnt++;
    if (r_nrd != 2 || r_npop != 2 || r_words != 2)
      $display("FAIL abort count: got %0d/%0d/%0d want 2/2/2",
        r_nrd, r_npop, r_words);
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    run_burst(0, 0, 0, -1, 100, 0, 0, -1, -1, "zero");
    chk_cnt++;
    if (r_done_c != 0 || r_nrd != 0 || r_words != 0)
      $display("FAIL zero: got c%0d rd%0d w%0d want c0 rd0 w0",
        r_done_c, r_nrd, r_words);
    else pass_cnt++;
  endtask

  task automatic test_start_busy();
    run_burst(2, 4, 0, -1, 100, 0, 0, -1, 1, "restart");
    chk_cnt++;
    if (r_nrd != 2 || r_words != 2)
      $display("FAIL restart count: got %0d/%0d want 2/2",
        r_nrd, r_words);
    else pass_cnt++;
    @(negedge rd_clk);
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL restart idle: got busy%b done%b want 0 0",
        busy, done);
    else pass_cnt++;
  endtask

  task automatic test_underflow();
    @(negedge rd_clk);
    chk_cnt++;
    if (err_underflow !== 1'b0)
      $display("FAIL uf pre: got %b want 0", err_underflow);
    else pass_cnt++;
    underflow = 1;
    @(negedge rd_clk);
    underflow = 0;
    chk_cnt++;
    if (err_underflow !== 1'b1)
      $display("FAIL uf set: got %b want 1", err_underflow);
    else pass_cnt++;
    repeat (3) @(negedge rd_clk);
    chk_cnt++;
    if (err_underflow !== 1'b1)
      $display("FAIL uf sticky: got %b want 1", err_underflow);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    fifo_clear();
    fifo_put(4);
    @(negedge rd_clk);
    start = 1; burst_len = 8'd4; m_ready = 0;
    @(negedge rd_clk);
    start = 0;
    repeat (5) @(negedge rd_clk);
    chk_cnt++;
    if (m_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL mid pre: got v%b busy%b want 1 1",
        m_valid, busy);
    else pass_cnt++;
    #2 rstn = 0;
    #1;
    chk_cnt++;
    if ({busy, done, words_out, err_underflow,
         rd_en, m_valid, m_data} !== 21'd0)
      $display("FAIL mid reset_outs: got %b want 0",
        {busy, done, words_out, err_underflow,
         rd_en, m_valid, m_data});
    else pass_cnt++;
    @(negedge rd_clk);
    rstn = 1;
    run_burst(1, 1, 0, -1, 100, 0, 0, -1, -1, "post");
    chk_cnt++;
    if (r_npop != 1 || r_words != 1)
      $display("FAIL post count: got %0d/%0d want 1/1",
        r_npop, r_words);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int len, pre, rdy;
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(12, 1);
      pre = $urandom_range(len, 0);
      rdy = $urandom_range(100, 30);
      run_burst(len, pre, len - pre,
        $urandom_range(20, 3), rdy, 0, 0, -1, -1, "rand");
      chk_cnt++;
      if (r_npop != len || r_words != len)
        $display("FAIL rand%0d count: got %0d/%0d want %0d",
          k, r_npop, r_words, len);
      else pass_cnt++;
    end
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0;
    rstn = 0; start = 0; burst_len = 0;
    abort = 0; underflow = 0; m_ready = 0;
    rd_data = 0; empty = 1;
    #2;
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_stall();
    test_abort();
    test_zero_len();
    test_start_busy();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
